// File: rtl/serial_compare_ctrl.sv
// serial_compare_ctrl
// Compares two WIDTH-bit unsigned operands one nibble per clock on a single
// 4-bit cascade comparator. The sequence runs from LSB nibble to MSB nibble,
// so higher nibbles override lower ones. WIDTH must be a multiple of 4 and >= 4.
module serial_compare_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic             iClk,
  input  logic             iRst_n,
  input  logic             iStart,
  input  logic             iClear,
  input  logic [WIDTH-1:0] iData_a,
  input  logic [WIDTH-1:0] iData_b,
  output logic             oBusy,
  output logic             oDone,
  output logic [2:0]       oResult
);

  localparam int NIB   = WIDTH / 4;
  localparam int IDX_W = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIB - 1);

  localparam logic [2:0] RES_GT   = 3'b100;
  localparam logic [2:0] RES_LT   = 3'b010;
  localparam logic [2:0] RES_EQ   = 3'b001;
  localparam logic [2:0] RES_NONE = 3'b000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] shifted_a;
  logic [WIDTH-1:0] shifted_b;
  logic [IDX_W-1:0] idx;
  logic [2:0]       cas;
  logic [2:0]       cmp;
  logic [3:0]       nib_a;
  logic [3:0]       nib_b;
  logic [2:0]       result;
  logic             done;
  logic             accept;
  logic             last_nib;

  assign accept   = (state == IDLE) && iStart && !iClear;
  assign last_nib = (idx == LAST_IDX);

  // Select the current nibble by shifting it down to the bottom of the operand.
  assign shifted_a = op_a >> {idx, 2'b00};
  assign shifted_b = op_b >> {idx, 2'b00};
  assign nib_a     = shifted_a[3:0];
  assign nib_b     = shifted_b[3:0];

  // The shared 4-bit cascade comparator: a differing nibble decides, otherwise pass the cascade on.
  always_comb begin
    cmp = cas;
    if (nib_a > nib_b) begin
      cmp = RES_GT;
    end else if (nib_a < nib_b) begin
      cmp = RES_LT;
    end
  end

  // State register.
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; iClear wins over everything and always returns to IDLE.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (accept) begin
          state_next = RUN;
        end
      end
      RUN: begin
        if (iClear) begin
          state_next = IDLE;
        end else if (last_nib) begin
          state_next = DONE;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Datapath: latch operands on accept, walk the nibbles in RUN, publish the verdict on the last one.
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      op_a   <= '0;
      op_b   <= '0;
      idx    <= '0;
      cas    <= RES_EQ;
      result <= RES_NONE;
    end else begin
      if (accept) begin
        op_a <= iData_a;
        op_b <= iData_b;
        idx  <= '0;
        cas  <= RES_EQ;
      end else if ((state == RUN) && !iClear) begin
        cas <= cmp;
        if (last_nib) begin
          result <= cmp;
        end else begin
          idx <= idx + 1'b1;
        end
      end
    end
  end

  // Done pulse: set only by a completed run, so it self-clears on the following edge.
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      done <= 1'b0;
    end else begin
      done <= (state == RUN) && !iClear && last_nib;
    end
  end

  assign oBusy   = (state != IDLE);
  assign oDone   = done;
  assign oResult = result;

endmodule

// File: tb/tb_serial_compare_ctrl.sv
// Self-checking bench for serial_compare_ctrl: a 16-bit and a 4-bit instance
// are exercised with directed and random operands against a plain-arithmetic model.
module tb_serial_compare_ctrl;

  logic clk = 1'b0;
  logic rst_n;

  logic        start16, clear16;
  logic [15:0] a16, b16;
  logic        busy16, done16;
  logic [2:0]  res16;

  logic        start4, clear4;
  logic [3:0]  a4, b4;
  logic        busy4, done4;
  logic [2:0]  res4;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  serial_compare_ctrl #(.WIDTH(16)) dut16 (
    .iClk(clk), .iRst_n(rst_n), .iStart(start16), .iClear(clear16),
    .iData_a(a16), .iData_b(b16),
    .oBusy(busy16), .oDone(done16), .oResult(res16)
  );

  serial_compare_ctrl #(.WIDTH(4)) dut4 (
    .iClk(clk), .iRst_n(rst_n), .iStart(start4), .iClear(clear4),
    .iData_a(a4), .iData_b(b4),
    .oBusy(busy4), .oDone(done4), .oResult(res4)
  );

  // Reference: whole-operand unsigned compare.
  function automatic logic [2:0] refCompare(input int unsigned a, input int unsigned b);
    if (a > b) return 3'b100;
    if (a < b) return 3'b010;
    return 3'b001;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic stepEdge();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus16(input logic [15:0] a, input logic [15:0] b);
    a16 = a;
    b16 = b;
    start16 = 1'b1;
    stepEdge();
    start16 = 1'b0;
    a16 = 16'($urandom);
    b16 = 16'($urandom);
    checkOutput("busy16_after_start", busy16, 1);
    checkOutput("done16_after_start", done16, 0);
  endtask

  task automatic runCompare16(input logic [15:0] a, input logic [15:0] b, input string tag);
    logic [2:0] exp;
    exp = refCompare(a, b);
    applyStimulus16(a, b);
    for (int i = 1; i <= 4; i++) begin
      stepEdge();
      if (i < 4) checkOutput({tag, "_early_done"}, done16, 0);
    end
    checkOutput({tag, "_done"}, done16, 1);
    checkOutput({tag, "_result"}, res16, exp);
    checkOutput({tag, "_busy_in_done"}, busy16, 1);
    stepEdge();
    checkOutput({tag, "_done_clear"}, done16, 0);
    checkOutput({tag, "_busy_clear"}, busy16, 0);
    checkOutput({tag, "_result_hold"}, res16, exp);
  endtask

  task automatic runCompare4(input logic [3:0] a, input logic [3:0] b, input string tag);
    logic [2:0] exp;
    exp = refCompare(a, b);
    a4 = a;
    b4 = b;
    start4 = 1'b1;
    stepEdge();
    start4 = 1'b0;
    a4 = 4'($urandom);
    b4 = 4'($urandom);
    checkOutput({tag, "_busy"}, busy4, 1);
    checkOutput({tag, "_early_done"}, done4, 0);
    stepEdge();
    checkOutput({tag, "_done"}, done4, 1);
    checkOutput({tag, "_result"}, res4, exp);
    stepEdge();
    checkOutput({tag, "_done_clear"}, done4, 0);
    checkOutput({tag, "_busy_clear"}, busy4, 0);
  endtask

  initial begin
    logic [15:0] ra, rb;
    logic [15:0] flip;
    int          done_count;

    rst_n   = 1'b0;
    start16 = 1'b0; clear16 = 1'b0; a16 = '0; b16 = '0;
    start4  = 1'b0; clear4  = 1'b0; a4  = '0; b4  = '0;
    #12;
    checkOutput("reset_busy16", busy16, 0);
    checkOutput("reset_done16", done16, 0);
    checkOutput("reset_res16", res16, 3'b000);
    checkOutput("reset_res4", res4, 3'b000);
    rst_n = 1'b1;
    stepEdge();

    // Directed cases from the 16-bit test plan.
    runCompare16(16'h1234, 16'h1234, "eq_1234");
    runCompare16(16'h8000, 16'h7FFF, "msb_override");
    runCompare16(16'h0001, 16'h0100, "lt_0001_0100");
    runCompare16(16'hABCD, 16'hABCC, "lsb_only");
    runCompare16(16'h0000, 16'hFFFF, "zero_vs_max");
    runCompare16(16'hFFFF, 16'hFFFF, "max_eq");

    // Start pulses during RUN must be ignored and not queued.
    applyStimulus16(16'h0005, 16'h0003);
    a16 = 16'h0000;
    start16 = 1'b1;
    stepEdge();
    stepEdge();
    start16 = 1'b0;
    done_count = 0;
    for (int i = 0; i < 6; i++) begin
      if (done16) done_count++;
      stepEdge();
    end
    checkOutput("ignored_start_done_count", done_count, 1);
    checkOutput("ignored_start_result", res16, 3'b100);
    checkOutput("ignored_start_no_rerun", busy16, 0);

    // Abort mid-run: no done, previous verdict stays.
    runCompare16(16'h0003, 16'h0005, "pre_abort");
    applyStimulus16(16'hFFFF, 16'h0000);
    stepEdge();
    clear16 = 1'b1;
    stepEdge();
    clear16 = 1'b0;
    checkOutput("abort_busy", busy16, 0);
    checkOutput("abort_done", done16, 0);
    checkOutput("abort_result", res16, 3'b010);
    done_count = 0;
    for (int i = 0; i < 4; i++) begin
      stepEdge();
      if (done16) done_count++;
    end
    checkOutput("abort_no_late_done", done_count, 0);
    checkOutput("abort_result_hold", res16, 3'b010);

    // Random operands, biased towards equal and single-nibble differences.
    for (int i = 0; i < 20; i++) begin
      ra = 16'($urandom);
      case ($urandom_range(0, 2))
        0: rb = 16'($urandom);
        1: rb = ra;
        default: begin
          flip = 16'($urandom_range(1, 15)) << (4 * $urandom_range(0, 3));
          rb = ra ^ flip;
        end
      endcase
      runCompare16(ra, rb, "rand16");
    end

    // 4-bit instance: random compares, then iClear behaviour in IDLE and DONE.
    for (int i = 0; i < 10; i++) begin
      runCompare4(4'($urandom), 4'($urandom), "rand4");
    end
    a4 = 4'h9; b4 = 4'h2;
    start4 = 1'b1;
    clear4 = 1'b1;
    stepEdge();
    start4 = 1'b0;
    clear4 = 1'b0;
    checkOutput("clear_beats_start_idle", busy4, 0);
    a4 = 4'h9; b4 = 4'h2;
    start4 = 1'b1;
    stepEdge();
    start4 = 1'b0;
    stepEdge();
    checkOutput("w4_done_before_clear", done4, 1);
    clear4 = 1'b1;
    start4 = 1'b1;
    stepEdge();
    clear4 = 1'b0;
    start4 = 1'b0;
    checkOutput("clear_in_done_done", done4, 0);
    checkOutput("clear_in_done_busy", busy4, 0);
    checkOutput("clear_in_done_result", res4, 3'b100);

    // Asynchronous reset between edges in the middle of a run.
    applyStimulus16(16'hFFFF, 16'h0000);
    stepEdge();
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async_rst_busy16", busy16, 0);
    checkOutput("async_rst_done16", done16, 0);
    checkOutput("async_rst_res16", res16, 3'b000);
    checkOutput("async_rst_res4", res4, 3'b000);
    #2;
    rst_n = 1'b1;
    done_count = 0;
    for (int i = 0; i < 5; i++) begin
      stepEdge();
      if (done16 || busy16) done_count++;
    end
    checkOutput("no_activity_after_reset", done_count, 0);
    runCompare4(4'h0, 4'h0, "w4_zero_after_reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
